hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage RISC-V core. Sits beside the FE_DE/DE_EX/EX_MEM registers. Each cycle it:
- generates the Execute-stage operand forwarding selects;
- detects load-use hazards and inserts one bubble;
- holds the front of the pipe while a multi-cycle multiply occupies Execute;
- flushes wrong-path instructions on a taken branch.

It replaces the constant forwarding selects now tied off at the Execute stage, and it counts stall cycles for performance debug.

## Interface
Parameters:
- MUL_LATENCY, 3, number of cycles a multiply occupies Execute (legal range 1–15).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- reg_read_addr1_d, reg_read_addr2_d  in  5  source registers of the instruction in Decode
- reg_read_addr1_e, reg_read_addr2_e  in  5  source registers of the instruction in Execute
- reg_write_addr_e, reg_write_en_e  in  5/1  destination register and write enable, Execute
- dmem_read_en_e  in  1  instruction in Execute is a load
- mul_en_e  in  1  instruction in Execute is a multiply
- reg_write_addr_m, reg_write_en_m  in  5/1  destination register and write enable, Memory
- reg_write_addr_w, reg_write_en_w  in  5/1  destination register and write enable, Writeback
- pc_branch_en  in  1  taken branch/jump resolved in Execute (bit 1 of pc_branch_en_sel)
- alumul_data1_sel_e  out  2  operand-1 source: 00 regfile, 01 execute_out_m, 10 reg_writedata_w
- alumul_forward_sel_e  out  2  operand-2 source, same encoding
- stall_f, stall_d, stall_e  out  1  hold PC, FE_DE and DE_EX respectively
- flush_fd, flush_de, flush_em  out  1  clear FE_DE, DE_EX, EX_MEM to a bubble
- busy  out  1  FSM is not in IDLE
- stall_count  out  32  cycles in which stall_f was asserted

## Operation
Forwarding (combinational):
- For each Execute source register src:
  - select 01 if reg_write_en_m && reg_write_addr_m == src && src != 0;
  - else select 10 if reg_write_en_w && reg_write_addr_w == src && src != 0;
  - else select 00.
- Memory stage has priority over Writeback. Register x0 is never forwarded.

Load-use hazard (combinational):
- Condition: dmem_read_en_e && reg_write_en_e && reg_write_addr_e != 0, and reg_write_addr_e equals reg_read_addr1_d or reg_read_addr2_d.
- Response: assert stall_f, stall_d and flush_de for exactly one cycle. The consumer then reads the loaded value through the Writeback forward.
- The match is on address only; it does not depend on whether the Decode instruction actually uses rs2.

Multiply FSM (states IDLE, MUL_BUSY; 4-bit counter cnt):
- IDLE, with mul_en_e, MUL_LATENCY > 1 and no branch: assert stall_f, stall_d, stall_e and flush_em; next state MUL_BUSY; cnt <= MUL_LATENCY-2.
- MUL_BUSY, cnt != 0: assert the same four signals; cnt <= cnt-1.
- MUL_BUSY, cnt == 0: drop all stalls so the result advances; next state IDLE. mul_en_e is ignored in this cycle, because it still refers to the same instruction.
- MUL_LATENCY == 1: the FSM never leaves IDLE.
- Result: a multiply holds Execute for MUL_LATENCY cycles and produces MUL_LATENCY-1 stall cycles.

Branch:
- pc_branch_en asserts flush_fd and flush_de, and suppresses stall_f and stall_d in that cycle.

Priority: reset > branch flush > multiply stall > load-use stall. A load-use condition seen while the multiply stall is active is re-evaluated once the stall releases.

stall_count:
- Increments by 1 in each cycle stall_f is 1.
- Wraps from 0xFFFFFFFF to 0.

## Timing
- Forward selects, stalls and flushes are combinational from the current inputs and the registered state, so they act in the same cycle.
- Registered elements are the FSM state, cnt and stall_count. They update on rising clk.
- Reset (synchronous):
  - state <= IDLE, cnt <= 0, stall_count <= 0;
  - while reset is high, every output is driven to 0.
- Reset asserted mid-multiply abandons the operation. Normal behaviour resumes on the first cycle after reset deasserts.
- Load-use costs 1 cycle. Multiply costs MUL_LATENCY-1 cycles. A branch costs 2 flushed slots.

## Structure
- Shared package (used by Execute_Stage and this block):
  - typedef for the 2-bit forward-select encoding (FWD_RF, FWD_MEM, FWD_WB);
  - typedef for the FSM state.
- One natural sub-module: `forward_unit`, the combinational select logic, instantiated once and driving both operand selects.

## Test plan
- Forwarding: x5 written in M and in W; Execute reads rs1=x5, rs2=x5 -> both selects 01. Clear reg_write_en_m -> both 10. Repeat with src=x0 -> 00.
- Load-use: lw x6 in Execute; add reading x6 in Decode -> stall_f=stall_d=flush_de=1 for one cycle, then 0. Next cycle, with the load in W, the select is 10.
- Multiply, MUL_LATENCY=3: mul_en_e held -> stall_e=flush_em=1 for 2 cycles, busy=1 for 2 cycles, then released. stall_count increases by 2. With MUL_LATENCY=1 -> no stall.
- Branch during load-use: pc_branch_en=1 together with a matching Decode read -> flush_fd=flush_de=1, stall_f=stall_d=0.
- Reset in the second cycle of MUL_BUSY: all outputs 0 and stall_count=0 the next cycle; busy=0 after reset deasserts.
- stall_count wrap: preload via 2^32 stall cycles, or force near the maximum -> after 0xFFFFFFFF it reads 0.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard controller and the Execute stage.
// Forward-select encoding and the multiply FSM state.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef logic [0:0] state_t;

  localparam state_t IDLE     = 1'b0;
  localparam state_t MUL_BUSY = 1'b1;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle.
// master is the pipeline side, slave is the controller.
interface hazard_controller_if;
  import hazard_controller_pkg::*;

  logic [4:0] reg_read_addr1_d;
  logic [4:0] reg_read_addr2_d;
  logic [4:0] reg_read_addr1_e;
  logic [4:0] reg_read_addr2_e;
  logic [4:0] reg_write_addr_e;
  logic       reg_write_en_e;
  logic       dmem_read_en_e;
  logic       mul_en_e;
  logic [4:0] reg_write_addr_m;
  logic       reg_write_en_m;
  logic [4:0] reg_write_addr_w;
  logic       reg_write_en_w;
  logic       pc_branch_en;

  fwd_sel_t    alumul_data1_sel_e;
  fwd_sel_t    alumul_forward_sel_e;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        flush_fd;
  logic        flush_de;
  logic        flush_em;
  logic        busy;
  logic [31:0] stall_count;

  modport master (
    output reg_read_addr1_d, reg_read_addr2_d,
    output reg_read_addr1_e, reg_read_addr2_e,
    output reg_write_addr_e, reg_write_en_e,
    output dmem_read_en_e, mul_en_e,
    output reg_write_addr_m, reg_write_en_m,
    output reg_write_addr_w, reg_write_en_w,
    output pc_branch_en,
    input  alumul_data1_sel_e, alumul_forward_sel_e,
    input  stall_f, stall_d, stall_e,
    input  flush_fd, flush_de, flush_em,
    input  busy, stall_count
  );

  modport slave (
    input  reg_read_addr1_d, reg_read_addr2_d,
    input  reg_read_addr1_e, reg_read_addr2_e,
    input  reg_write_addr_e, reg_write_en_e,
    input  dmem_read_en_e, mul_en_e,
    input  reg_write_addr_m, reg_write_en_m,
    input  reg_write_addr_w, reg_write_en_w,
    input  pc_branch_en,
    output alumul_data1_sel_e, alumul_forward_sel_e,
    output stall_f, stall_d, stall_e,
    output flush_fd, flush_de, flush_em,
    output busy, stall_count
  );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Execute-stage operand forwarding selects for both sources.
// Memory wins over Writeback; x0 is never forwarded.
module forward_unit
  import hazard_controller_pkg::*;
(
  input  logic     m_en,
  input  logic [4:0] m_addr,
  input  logic     w_en,
  input  logic [4:0] w_addr,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  output fwd_sel_t sel1,
  output fwd_sel_t sel2
);

  function automatic fwd_sel_t pick(
    input logic       me,
    input logic [4:0] ma,
    input logic       we,
    input logic [4:0] wa,
    input logic [4:0] src
  );
    logic hit_m;
    logic hit_w;
    fwd_sel_t sel;
    hit_m = me && (ma == src) && (src != 5'd0);
    hit_w = we && (wa == src) && (src != 5'd0) && !hit_m;
    sel = FWD_RF;
    unique case (1'b1)
      hit_m:   sel = FWD_MEM;
      hit_w:   sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
    return sel;
  endfunction

  assign sel1 = pick(m_en, m_addr, w_en, w_addr, src1);
  assign sel2 = pick(m_en, m_addr, w_en, w_addr, src2);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: forwarding, load-use bubble,
// multiply hold, branch flush and stall-cycle counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input logic clk,
  input logic reset,
  hazard_controller_if.slave hz
);

  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [3:0] CNT_INIT =
    MUL_MULTI ? 4'(MUL_LATENCY - 2) : 4'd0;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] stall_count_q;

  fwd_sel_t sel1;
  fwd_sel_t sel2;

  logic br;
  logic load_use;
  logic mul_start;
  logic mul_hold;
  logic stall_fd;

  forward_unit u_fwd (
    .m_en   (hz.reg_write_en_m),
    .m_addr (hz.reg_write_addr_m),
    .w_en   (hz.reg_write_en_w),
    .w_addr (hz.reg_write_addr_w),
    .src1   (hz.reg_read_addr1_e),
    .src2   (hz.reg_read_addr2_e),
    .sel1   (sel1),
    .sel2   (sel2)
  );

  assign br = hz.pc_branch_en;

  // Address-only match: rs2 is compared even if unused.
  assign load_use = hz.dmem_read_en_e
    && hz.reg_write_en_e
    && (hz.reg_write_addr_e != 5'd0)
    && ((hz.reg_write_addr_e == hz.reg_read_addr1_d)
     || (hz.reg_write_addr_e == hz.reg_read_addr2_d));

  assign mul_start = (state_q == IDLE)
    && hz.mul_en_e && MUL_MULTI && !br;

  assign mul_hold = mul_start
    || ((state_q == MUL_BUSY) && (cnt_q != 4'd0));

  assign stall_fd = !br && (mul_hold || load_use);

  assign hz.alumul_data1_sel_e   = reset ? FWD_RF : sel1;
  assign hz.alumul_forward_sel_e = reset ? FWD_RF : sel2;
  assign hz.stall_f  = !reset && stall_fd;
  assign hz.stall_d  = !reset && stall_fd;
  assign hz.stall_e  = !reset && mul_hold;
  assign hz.flush_em = !reset && mul_hold;
  assign hz.flush_fd = !reset && br;
  assign hz.flush_de = !reset
    && (br || (load_use && !mul_hold));
  assign hz.busy = !reset && (state_q != IDLE);
  assign hz.stall_count = reset ? 32'd0 : stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (stall_fd)
        stall_count_q <= stall_count_q + 32'd1;
      unique case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q <= MUL_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        MUL_BUSY: begin
          if (cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
          else
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: a spec model predicts each cycle's
// outputs, queues them, and they are compared mid-cycle.
module tb_hazard_controller;

  localparam int L = 3;

  typedef struct packed {
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        sf;
    logic        sd;
    logic        se;
    logic        ffd;
    logic        fde;
    logic        fem;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if bus ();
  hazard_controller_if bus1 ();

  assign bus1.reg_read_addr1_d = bus.reg_read_addr1_d;
  assign bus1.reg_read_addr2_d = bus.reg_read_addr2_d;
  assign bus1.reg_read_addr1_e = bus.reg_read_addr1_e;
  assign bus1.reg_read_addr2_e = bus.reg_read_addr2_e;
  assign bus1.reg_write_addr_e = bus.reg_write_addr_e;
  assign bus1.reg_write_en_e   = bus.reg_write_en_e;
  assign bus1.dmem_read_en_e   = bus.dmem_read_en_e;
  assign bus1.mul_en_e         = bus.mul_en_e;
  assign bus1.reg_write_addr_m = bus.reg_write_addr_m;
  assign bus1.reg_write_en_m   = bus.reg_write_en_m;
  assign bus1.reg_write_addr_w = bus.reg_write_addr_w;
  assign bus1.reg_write_en_w   = bus.reg_write_en_w;
  assign bus1.pc_branch_en     = bus.pc_branch_en;

  hazard_controller #(.MUL_LATENCY(L)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

  hazard_controller #(.MUL_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .hz    (bus1.slave)
  );

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];

  int unsigned phase = 0;
  logic [31:0] m_count = 32'd0;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (bus.reg_write_en_m && bus.reg_write_addr_m == src)
      return 2'b01;
    if (bus.reg_write_en_w && bus.reg_write_addr_w == src)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic lu;
    logic ms;
    logic br;
    e = '0;
    if (reset) return e;
    br = bus.pc_branch_en;
    lu = bus.dmem_read_en_e && bus.reg_write_en_e
      && bus.reg_write_addr_e != 5'd0
      && (bus.reg_write_addr_e == bus.reg_read_addr1_d
       || bus.reg_write_addr_e == bus.reg_read_addr2_d);
    ms = (phase == 0 && bus.mul_en_e && L > 1 && !br)
      || (phase >= 1 && phase <= L - 2);
    e.s1   = fsel(bus.reg_read_addr1_e);
    e.s2   = fsel(bus.reg_read_addr2_e);
    e.sf   = !br && (ms || lu);
    e.sd   = e.sf;
    e.se   = ms;
    e.fem  = ms;
    e.ffd  = br;
    e.fde  = br || (lu && !ms);
    e.busy = (phase != 0);
    e.cnt  = m_count;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    exp_t x;
    e = model();
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    check("sel1", 32'(bus.alumul_data1_sel_e), 32'(x.s1));
    check("sel2", 32'(bus.alumul_forward_sel_e), 32'(x.s2));
    check("stall_f", 32'(bus.stall_f), 32'(x.sf));
    check("stall_d", 32'(bus.stall_d), 32'(x.sd));
    check("stall_e", 32'(bus.stall_e), 32'(x.se));
    check("flush_fd", 32'(bus.flush_fd), 32'(x.ffd));
    check("flush_de", 32'(bus.flush_de), 32'(x.fde));
    check("flush_em", 32'(bus.flush_em), 32'(x.fem));
    check("busy", 32'(bus.busy), 32'(x.busy));
    check("stall_count", bus.stall_count, x.cnt);
    @(posedge clk);
    if (reset) begin
      phase = 0;
      m_count = 32'd0;
    end else begin
      if (e.sf) m_count = m_count + 32'd1;
      if (phase == 0) begin
        if (bus.mul_en_e && L > 1 && !bus.pc_branch_en)
          phase = 1;
      end else if (phase == L - 1) begin
        phase = 0;
      end else begin
        phase = phase + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.reg_read_addr1_d = 5'd0;
    bus.reg_read_addr2_d = 5'd0;
    bus.reg_read_addr1_e = 5'd0;
    bus.reg_read_addr2_e = 5'd0;
    bus.reg_write_addr_e = 5'd0;
    bus.reg_write_en_e   = 1'b0;
    bus.dmem_read_en_e   = 1'b0;
    bus.mul_en_e         = 1'b0;
    bus.reg_write_addr_m = 5'd0;
    bus.reg_write_en_m   = 1'b0;
    bus.reg_write_addr_w = 5'd0;
    bus.reg_write_en_w   = 1'b0;
    bus.pc_branch_en     = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    bus.dmem_read_en_e   = 1'b1;
    bus.reg_write_en_e   = 1'b1;
    bus.reg_write_addr_e = rd;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_m = 5'd5;
    bus.reg_read_addr1_e = 5'd5;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    quiet();

    // forwarding: M and W both hold x5
    bus.reg_read_addr1_e = 5'd5;
    bus.reg_read_addr2_e = 5'd5;
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_m = 5'd5;
    bus.reg_write_en_w   = 1'b1;
    bus.reg_write_addr_w = 5'd5;
    tick();
    bus.reg_write_en_m = 1'b0;
    tick();
    bus.reg_read_addr1_e = 5'd0;
    bus.reg_read_addr2_e = 5'd0;
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_m = 5'd0;
    bus.reg_write_addr_w = 5'd0;
    tick();
    bus.reg_read_addr1_e = 5'd9;
    bus.reg_read_addr2_e = 5'd7;
    bus.reg_write_addr_m = 5'd9;
    bus.reg_write_addr_w = 5'd7;
    tick();

    // load-use: lw x6 in E, add x6 in D
    quiet();
    set_load(5'd6);
    bus.reg_read_addr1_d = 5'd6;
    bus.reg_read_addr2_d = 5'd2;
    tick();
    quiet();
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_m = 5'd6;
    bus.reg_read_addr1_d = 5'd6;
    tick();
    quiet();
    bus.reg_read_addr1_e = 5'd6;
    bus.reg_write_en_w   = 1'b1;
    bus.reg_write_addr_w = 5'd6;
    tick();
    quiet();
    set_load(5'd0);
    tick();
    set_load(5'd4);
    bus.reg_read_addr2_d = 5'd4;
    tick();

    // multiply held for MUL_LATENCY cycles
    quiet();
    bus.mul_en_e = 1'b1;
    for (int i = 0; i < L; i++) begin
      #1;
      check("lat1_stall_e", 32'(bus1.stall_e), 32'd0);
      check("lat1_busy", 32'(bus1.busy), 32'd0);
      tick();
    end
    bus.mul_en_e = 1'b0;
    tick();
    check("mul_stall_total", 32'(m_count), 32'd4);

    // load-use seen during a multiply hold
    bus.mul_en_e = 1'b1;
    set_load(5'd8);
    bus.reg_read_addr1_d = 5'd8;
    tick();
    tick();
    tick();
    quiet();
    tick();

    // branch together with a load-use match
    set_load(5'd6);
    bus.reg_read_addr1_d = 5'd6;
    bus.pc_branch_en     = 1'b1;
    tick();
    bus.mul_en_e = 1'b1;
    tick();
    quiet();
    tick();

    // reset inside MUL_BUSY
    bus.mul_en_e = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mul_en_e = 1'b0;
    tick();
    tick();

    // counter wrap from a preloaded near-max value
    force u_dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.stall_count_q;
    m_count = 32'hFFFF_FFFE;
    set_load(5'd3);
    bus.reg_read_addr2_d = 5'd3;
    tick();
    tick();
    quiet();
    tick();
    check("wrap_zero", bus.stall_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
